text_console_writer: RTL
========================

Name: text_console_writer

Overview:
- Producer side of the text-mode character RAM: accepts a byte stream of ASCII characters and control codes, tracks a cursor, and drives the RAM write port.
- Writes cell address, data and write enable into the text buffer, which the display path reads at 40 columns x 15 rows (2x zoom of 640x480).
- Handles screen clear, cursor positioning and line wrap, so upstream logic (wav player status and menu) only emits characters.

Parameters:
- NUM_COLUMNS, 40, characters per row; cell address = col + row*NUM_COLUMNS.
- NUM_ROWS, 15, rows on screen.
- ADDR_WIDTH, 13, width of the RAM write address.
- FILL_CHAR, 8'h20, byte written to every cell during a clear.
- SUBST_CHAR, 8'h3F, byte written in place of codes 0x80-0xFF.

Ports:
- clk  in  1  write clock; same clock as the RAM write clock (wrclk domain).
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  character byte present.
- in_data  in  8  character or control code.
- in_ready  out  1  byte accepted when in_valid && in_ready at posedge.
- set_pos  in  1  one-cycle request to move the cursor.
- set_col  in  6  target column for set_pos.
- set_row  in  4  target row for set_pos.
- clr  in  1  one-cycle request to clear the screen and home the cursor.
- busy  out  1  high while a clear sweep is running.
- cur_col  out  6  current cursor column.
- cur_row  out  4  current cursor row.
- ram_waddr  out  ADDR_WIDTH  cell address.
- ram_wdata  out  8  cell data.
- ram_wren  out  1  write strobe, one cycle per cell written.

Behaviour:
- Reset (async, rst_n low):
  - ram_wren=0, ram_waddr=0, ram_wdata=0, cur_col=0, cur_row=0, in_ready=0.
  - State is CLEAR and busy=1 from the first clock edge after rst_n rises.
  - Reset asserted mid-sweep or mid-write aborts the operation; a fresh full clear runs after release.
- States: CLEAR and IDLE.
- CLEAR:
  - Sweep counter runs 0..NUM_COLUMNS*NUM_ROWS-1 (0..599), one cell per cycle.
  - Each cycle: ram_wren=1, ram_waddr=counter, ram_wdata=FILL_CHAR.
  - After cell 599: go to IDLE, cursor=(0,0).
  - busy=1 and in_ready=0 throughout.
  - A sweep is exactly 600 consecutive strobe cycles.
  - clr during CLEAR restarts the sweep at 0.
- IDLE:
  - in_ready = !set_pos && !clr.
  - Priority: clr > set_pos > byte.
  - clr enters CLEAR next cycle.
  - set_pos loads the cursor next cycle. set_col >= NUM_COLUMNS clamps to NUM_COLUMNS-1; set_row >= NUM_ROWS clamps to NUM_ROWS-1.
- Accepted byte, decoded at the handshake edge. All outputs are registered, so ram_wren pulses for exactly the one cycle after the handshake.
  - 0x20-0x7E: write the byte at the current cell, then advance the cursor.
  - 0x80-0xFF: write SUBST_CHAR, then advance the cursor.
  - 0x0A: col=0, row+1. No write.
  - 0x0D: col=0. No write.
  - 0x09: col = next multiple of 8. If that is >= NUM_COLUMNS, behave as 0x0A. No write.
  - 0x08: if col>0, col-1; at col 0 no change. No write.
  - 0x0C: equivalent to clr. The byte is consumed.
  - Any other code < 0x20, or 0x7F: consumed, no effect.
- Cursor advance:
  - col+1. At col NUM_COLUMNS-1 it wraps to col 0, row+1.
  - Row increments past NUM_ROWS-1 wrap to row 0 (no scrolling).
  - Cursor outputs update in the same cycle ram_wren is high, and hold the post-advance position.
- Address arithmetic is unsigned: row*NUM_COLUMNS + col, computed at full ADDR_WIDTH with no truncation for the default geometry (max 599).
- Sustained throughput is one byte per cycle in IDLE. No wait state is needed between writes.
- When not writing, ram_wren=0; ram_waddr and ram_wdata hold their last values.

Test Plan:
- Reset release -> exactly 600 ram_wren cycles, addresses 0..599 in order, data 0x20; then busy=0, in_ready=1, cursor (0,0).
- set_pos col=5,row=2, then bytes 'W','A','V' (0x57,0x41,0x56) back-to-back -> writes at 85, 86, 87 with those data on consecutive cycles; cursor ends (8,2).
- set_pos col=39,row=14, then 'X', 'Y' -> 'X' at 599, 'Y' at 0; cursor (1,0).
- After 'AB' at (0,0), send 0x0A, 0x09, 'C' -> 'C' written at 48 (row1,col8); 0x0A and 0x09 produce no ram_wren.
- Bytes 0x85 then 0x07 at (3,0) -> 0x3F written at 3; 0x07 produces no write; cursor (4,0).
- clr asserted during a character stream -> in_ready=0 that cycle, 600-cycle sweep follows; second clr at sweep cell 300 restarts at 0; rst_n pulse at cell 100 -> outputs zero immediately, full sweep after release.

Source files
------------

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character stream to text RAM writer with cursor, wrap and clear sweep
module text_console_writer #(
    parameter int          NUM_COLUMNS = 40,
    parameter int          NUM_ROWS    = 15,
    parameter int          ADDR_WIDTH  = 13,
    parameter logic [7:0]  FILL_CHAR   = 8'h20,
    parameter logic [7:0]  SUBST_CHAR  = 8'h3F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  set_pos,
    input  logic [5:0]            set_col,
    input  logic [3:0]            set_row,
    input  logic                  clr,
    output logic                  busy,
    output logic [5:0]            cur_col,
    output logic [3:0]            cur_row,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_wren
);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    localparam int                    NUM_CELLS    = NUM_COLUMNS * NUM_ROWS;
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_CELL = ADDR_WIDTH'(NUM_CELLS - 1);
    localparam logic [5:0]            LP_COL_MAX   = 6'(NUM_COLUMNS - 1);
    localparam logic [3:0]            LP_ROW_MAX   = 4'(NUM_ROWS - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [5:0]            r_col;
    logic [3:0]            r_row;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wdata;
    logic                  r_wren;
    logic                  r_busy;
    logic                  r_idle_rdy;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_cell_addr;
    logic [ADDR_WIDTH-1:0] w_sweep_addr;
    logic [3:0]            w_row_inc;
    logic [5:0]            w_adv_col;
    logic [3:0]            w_adv_row;
    logic [5:0]            w_tab_col;
    logic [5:0]            w_pos_col;
    logic [3:0]            w_pos_row;

    // Handshake, address and next-cursor arithmetic shared by the sequencer
    always_comb begin
        // in_ready stays low for the first IDLE cycle after a sweep so busy and ready never overlap
        w_in_ready   = r_idle_rdy && (r_state == S_IDLE) && !set_pos && !clr;
        w_accept     = in_valid && w_in_ready;
        w_cell_addr  = ADDR_WIDTH'(r_row) * ADDR_WIDTH'(NUM_COLUMNS) + ADDR_WIDTH'(r_col);
        // A clr mid-sweep restarts at cell 0 on this very edge, keeping the strobe continuous
        w_sweep_addr = clr ? '0 : r_cnt;
        w_row_inc    = (r_row >= LP_ROW_MAX) ? 4'd0 : r_row + 4'd1;
        if (r_col >= LP_COL_MAX) begin
            w_adv_col = 6'd0;
            w_adv_row = w_row_inc;
        end else begin
            w_adv_col = r_col + 6'd1;
            w_adv_row = r_row;
        end
        w_tab_col    = {r_col[5:3] + 3'd1, 3'b000};
        w_pos_col    = (set_col > LP_COL_MAX) ? LP_COL_MAX : set_col;
        w_pos_row    = (set_row > LP_ROW_MAX) ? LP_ROW_MAX : set_row;
    end

    // Clear sweep / idle command sequencer with registered RAM port and cursor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_col      <= 6'd0;
            r_row      <= 4'd0;
            r_waddr    <= '0;
            r_wdata    <= 8'h00;
            r_wren     <= 1'b0;
            r_busy     <= 1'b0;
            r_idle_rdy <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_wren     <= 1'b1;
                    r_waddr    <= w_sweep_addr;
                    r_wdata    <= FILL_CHAR;
                    r_busy     <= 1'b1;
                    r_idle_rdy <= 1'b0;
                    if (w_sweep_addr == LP_LAST_CELL) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_col   <= 6'd0;
                        r_row   <= 4'd0;
                    end else begin
                        r_cnt <= w_sweep_addr + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_idle_rdy <= 1'b1;
                    if (clr || (w_accept && in_data == 8'h0C)) begin
                        r_state    <= S_CLEAR;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_idle_rdy <= 1'b0;
                    end else if (set_pos) begin
                        r_col <= w_pos_col;
                        r_row <= w_pos_row;
                    end else if (w_accept) begin
                        if (in_data >= 8'h80) begin
                            r_wren  <= 1'b1;
                            r_waddr <= w_cell_addr;
                            r_wdata <= SUBST_CHAR;
                            r_col   <= w_adv_col;
                            r_row   <= w_adv_row;
                        end else if (in_data >= 8'h20 && in_data != 8'h7F) begin
                            r_wren  <= 1'b1;
                            r_waddr <= w_cell_addr;
                            r_wdata <= in_data;
                            r_col   <= w_adv_col;
                            r_row   <= w_adv_row;
                        end else begin
                            case (in_data)
                                8'h0A: begin
                                    r_col <= 6'd0;
                                    r_row <= w_row_inc;
                                end
                                8'h0D: r_col <= 6'd0;
                                8'h09: begin
                                    if (w_tab_col > LP_COL_MAX) begin
                                        r_col <= 6'd0;
                                        r_row <= w_row_inc;
                                    end else begin
                                        r_col <= w_tab_col;
                                    end
                                end
                                8'h08: begin
                                    if (r_col != 6'd0) r_col <= r_col - 6'd1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = r_busy;
    assign cur_col   = r_col;
    assign cur_row   = r_row;
    assign ram_waddr = r_waddr;
    assign ram_wdata = r_wdata;
    assign ram_wren  = r_wren;

endmodule
